csr_unit: RTL and testbench

Machine-mode CSR file for the tinyriscv core, and the parametrised successor to the fixed 32-bit CSR register bank. It performs the read-modify-write operations (RW/RS/RC) requested by ex, with illegal-access detection. It also provides configurable-width cycle and instret counters, hardware trap entry and mret stacking of mstatus, registered interrupt pending bits, and a vectored trap-target computation consumed by clint.

---
 rtl/csr_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_csr_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file for tinyriscv
// RW/RS/RC access, counters, trap entry/mret, vectored trap target
module csr_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int unsigned     HART_ID     = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            global_int_en_o,
  output logic            irq_pending_o
);

  localparam int unsigned CW2 = 2 * XLEN;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTR    = 12'hC02;
  localparam logic [11:0] A_INSTRH   = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h0000_0888);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;

  logic [CW2-1:0]  cyc_ext;
  logic [CW2-1:0]  ins_ext;
  logic [XLEN-1:0] rd_raw;
  logic [XLEN-1:0] wval;
  logic            mapped;
  logic            ro;
  logic            wnz;
  logic            csr_we;

  assign cyc_ext = CW2'(mcycle_q);
  assign ins_ext = CW2'(minstret_q);
  assign wnz     = |csr_wdata_i;

  // Address decode and read mux from registered state
  always_comb begin
    rd_raw = '0;
    mapped = 1'b1;
    ro     = 1'b0;
    unique case (csr_addr_i)
      A_MSTATUS: begin
        rd_raw[12:11] = 2'b11;
        rd_raw[7]     = mstatus_mpie_q;
        rd_raw[3]     = mstatus_mie_q;
      end
      A_MISA:     ro = 1'b1;
      A_MIE:      rd_raw = mie_q;
      A_MTVEC:    rd_raw = mtvec_q & ~XLEN'(2);
      A_MSCRATCH: rd_raw = mscratch_q;
      A_MEPC:     rd_raw = mepc_q;
      A_MCAUSE:   rd_raw = mcause_q;
      A_MTVAL:    rd_raw = mtval_q;
      A_MIP: begin
        rd_raw = mip_q;
        ro     = 1'b1;
      end
      A_MCYCLE:   rd_raw = cyc_ext[XLEN-1:0];
      A_MCYCLEH:  rd_raw = cyc_ext[CW2-1:XLEN];
      A_MINSTR:   rd_raw = ins_ext[XLEN-1:0];
      A_MINSTRH:  rd_raw = ins_ext[CW2-1:XLEN];
      A_CYCLE: begin
        rd_raw = cyc_ext[XLEN-1:0];
        ro     = 1'b1;
      end
      A_CYCLEH: begin
        rd_raw = cyc_ext[CW2-1:XLEN];
        ro     = 1'b1;
      end
      A_INSTR: begin
        rd_raw = ins_ext[XLEN-1:0];
        ro     = 1'b1;
      end
      A_INSTRH: begin
        rd_raw = ins_ext[CW2-1:XLEN];
        ro     = 1'b1;
      end
      A_MHARTID: begin
        rd_raw = XLEN'(HART_ID);
        ro     = 1'b1;
      end
      default:    mapped = 1'b0;
    endcase
  end

  // Legality, read data and read-modify-write value
  always_comb begin
    csr_illegal_o = (csr_op_i != OP_NONE) &&
                    (!mapped || (ro && (csr_op_i == OP_RW || wnz)));
    csr_rdata_o   = csr_illegal_o ? '0 : rd_raw;
    csr_we        = (csr_op_i != OP_NONE) && !csr_illegal_o &&
                    (csr_op_i == OP_RW || wnz);
    unique case (csr_op_i)
      OP_RW:   wval = csr_wdata_i;
      OP_RS:   wval = rd_raw | csr_wdata_i;
      default: wval = rd_raw & ~csr_wdata_i;
    endcase
  end

  // Next state: CSR write first, then mret and trap override shared fields
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mip_d          = '0;
    mip_d[11]      = irq_i[2];
    mip_d[7]       = irq_i[1];
    mip_d[3]       = irq_i[0];
    mcycle_d       = mcycle_q + CNT_W'(1);
    minstret_d     = minstret_q + CNT_W'(retire_i);
    if (csr_we) begin
      unique case (csr_addr_i)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:      mie_d = wval & IRQ_MASK;
        A_MTVEC:    mtvec_d = wval;
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d = wval & ~XLEN'(1);
        A_MCAUSE:   mcause_d = wval;
        A_MTVAL:    mtval_d = wval;
        A_MCYCLE:
          mcycle_d = CNT_W'({cyc_ext[CW2-1:XLEN], wval});
        A_MCYCLEH:
          mcycle_d = CNT_W'({wval, cyc_ext[XLEN-1:0]});
        A_MINSTR:
          minstret_d = CNT_W'({ins_ext[CW2-1:XLEN], wval});
        A_MINSTRH:
          minstret_d = CNT_W'({wval, ins_ext[XLEN-1:0]});
        default: ;
      endcase
    end
    if (trap_i) begin
      mepc_d         = trap_pc_i & ~XLEN'(1);
      mcause_d       = trap_cause_i;
      mtval_d        = trap_val_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Vectored target adds 4*cause only for interrupts
  always_comb begin
    trap_target_o = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[XLEN-1])
      trap_target_o = trap_target_o + {trap_cause_i[XLEN-3:0], 2'b00};
  end

  assign mepc_o          = mepc_q;
  assign global_int_en_o = mstatus_mie_q;
  assign irq_pending_o   = mstatus_mie_q && |(mie_q & mip_q);

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: csr_unit against a behavioural CSR model
// directed scenarios followed by random traffic
module tb_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  csr_op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        retire_i = 1'b0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_pc_i = '0;
  logic [31:0] trap_val_i = '0;
  logic        mret_i = 1'b0;
  logic [2:0]  irq_i = '0;
  logic [31:0] trap_target_o;
  logic [31:0] mepc_o;
  logic        global_int_en_o;
  logic        irq_pending_o;

  csr_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .retire_i(retire_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i),
    .mret_i(mret_i), .irq_i(irq_i),
    .trap_target_o(trap_target_o), .mepc_o(mepc_o),
    .global_int_en_o(global_int_en_o),
    .irq_pending_o(irq_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic        m_gie, m_mpie;
  logic [31:0] m_mie, m_mip, m_mtvec, m_mscratch;
  logic [31:0] m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  logic [31:0] last_rd, last_tgt;
  logic        last_ill;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_gie = 0; m_mpie = 0;
    m_mie = 0; m_mip = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  function automatic void mread(input logic [11:0] a,
      output logic mp, output logic ro, output logic [31:0] v);
    mp = 1; ro = 0; v = 0;
    case (a)
      12'h300: begin
        v = 32'h1800;
        if (m_mpie) v |= 32'h80;
        if (m_gie) v |= 32'h8;
      end
      12'h301: ro = 1;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec & ~32'h2;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin v = m_mip; ro = 1; end
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hC00: begin v = m_cyc[31:0]; ro = 1; end
      12'hC80: begin v = m_cyc[63:32]; ro = 1; end
      12'hC02: begin v = m_ins[31:0]; ro = 1; end
      12'hC82: begin v = m_ins[63:32]; ro = 1; end
      12'hF14: ro = 1;
      default: mp = 0;
    endcase
  endfunction

  function automatic logic m_illegal(input logic [1:0] op,
      input logic [11:0] a, input logic [31:0] wd);
    logic mp, ro;
    logic [31:0] v;
    mread(a, mp, ro, v);
    return op != 0 && (!mp || (ro && (op == 2'b01 || wd != 0)));
  endfunction

  task automatic m_update(input logic [1:0] op, input logic [11:0] a,
      input logic [31:0] wd, input logic tr, input logic [31:0] ca,
      input logic [31:0] pc, input logic [31:0] va, input logic mr,
      input logic rt, input logic [2:0] ir);
    logic mp, ro, we, cw, iw, ogie, ompie;
    logic [31:0] old, nv;
    mread(a, mp, ro, old);
    we = !m_illegal(op, a, wd) && op != 0 && (op == 2'b01 || wd != 0);
    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
    ogie = m_gie; ompie = m_mpie;
    cw = 0; iw = 0;
    if (we) begin
      case (a)
        12'h300: begin m_gie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie = nv & 32'h888;
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h1;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: begin m_cyc[31:0] = nv; cw = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cw = 1; end
        12'hB02: begin m_ins[31:0] = nv; iw = 1; end
        12'hB82: begin m_ins[63:32] = nv; iw = 1; end
        default: ;
      endcase
    end
    if (!cw) m_cyc = m_cyc + 1;
    if (!iw && rt) m_ins = m_ins + 1;
    if (tr) begin
      m_mepc = pc & ~32'h1;
      m_mcause = ca;
      m_mtval = va;
      m_mpie = ogie;
      m_gie = 0;
    end else if (mr) begin
      m_gie = ompie;
      m_mpie = 1;
    end
    m_mip = 0;
    if (ir[2]) m_mip |= 32'h800;
    if (ir[1]) m_mip |= 32'h080;
    if (ir[0]) m_mip |= 32'h008;
  endtask

  // One clock: drive at posedge+1, check mid-cycle, advance model after edge
  task automatic step(input logic [1:0] op, input logic [11:0] a,
      input logic [31:0] wd, input logic tr, input logic [31:0] ca,
      input logic [31:0] pc, input logic [31:0] va, input logic mr,
      input logic rt, input logic [2:0] ir);
    logic mp, ro, ill;
    logic [31:0] v, tgt;
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
    trap_i = tr; trap_cause_i = ca; trap_pc_i = pc; trap_val_i = va;
    mret_i = mr; retire_i = rt; irq_i = ir;
    #4;
    mread(a, mp, ro, v);
    ill = m_illegal(op, a, wd);
    tgt = m_mtvec & ~32'h3;
    if (m_mtvec[0] && ca[31]) tgt = tgt + (ca & 32'h7FFF_FFFF) * 4;
    last_rd = csr_rdata_o;
    last_ill = csr_illegal_o;
    last_tgt = trap_target_o;
    chk("rdata", csr_rdata_o, ill ? 32'h0 : v);
    chk("illegal", {31'b0, csr_illegal_o}, {31'b0, ill});
    chk("target", trap_target_o, tgt);
    chk("mepc_o", mepc_o, m_mepc);
    chk("gie", {31'b0, global_int_en_o}, {31'b0, m_gie});
    chk("irq_pend", {31'b0, irq_pending_o},
        {31'b0, m_gie && ((m_mie & m_mip) != 0)});
    @(posedge clk_i);
    #1;
    m_update(op, a, wd, tr, ca, pc, va, mr, rt, ir);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] wd);
    step(op, a, wd, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  logic [11:0] alist [20] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
    12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7FF, 12'h000
  };

  initial begin
    m_reset();
    csr_addr_i = 12'h300;
    #2;
    chk("rst_mstatus", csr_rdata_o, 32'h0000_1800);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_pend", {31'b0, irq_pending_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    csr(2'b01, 12'h340, 32'hA5A5_0F0F);
    chk("rmw_rw", last_rd, 32'h0);
    csr(2'b10, 12'h340, 32'h0000_F000);
    chk("rmw_rs", last_rd, 32'hA5A5_0F0F);
    csr(2'b11, 12'h340, 32'h0000_000F);
    chk("rmw_rc", last_rd, 32'hA5A5_FF0F);
    csr(2'b00, 12'h340, 32'h0);
    chk("rmw_final", last_rd, 32'hA5A5_FF00);

    csr(2'b01, 12'hC00, 32'h1);
    chk("ill_ro", {31'b0, last_ill}, 32'h1);
    csr(2'b01, 12'h7FF, 32'h0);
    chk("ill_unmap", {31'b0, last_ill}, 32'h1);
    csr(2'b10, 12'hF14, 32'h0);
    chk("hartid_ok", {31'b0, last_ill}, 32'h0);
    chk("hartid", last_rd, 32'h0);

    csr(2'b10, 12'h300, 32'h8);
    step(0, 12'h000, 0, 1, 32'h8000_0007, 32'h0000_0123, 32'h55, 0, 0, 0);
    csr(2'b00, 12'h341, 32'h0);
    chk("trap_mepc", last_rd, 32'h0000_0122);
    csr(2'b00, 12'h342, 32'h0);
    chk("trap_mcause", last_rd, 32'h8000_0007);
    csr(2'b00, 12'h343, 32'h0);
    chk("trap_mtval", last_rd, 32'h55);
    csr(2'b00, 12'h300, 32'h0);
    chk("trap_mstatus", last_rd, 32'h0000_1880);
    step(0, 12'h300, 0, 0, 0, 0, 0, 1, 0, 0);
    csr(2'b00, 12'h300, 32'h0);
    chk("mret_mstatus", last_rd, 32'h0000_1888);

    csr(2'b01, 12'h305, 32'h0000_1001);
    step(0, 12'h305, 0, 0, 32'h8000_0007, 0, 0, 0, 0, 0);
    chk("vec_irq", last_tgt, 32'h0000_101C);
    step(0, 12'h305, 0, 0, 32'h0000_0002, 0, 0, 0, 0, 0);
    chk("vec_exc", last_tgt, 32'h0000_1000);

    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    csr(2'b00, 12'hB00, 32'h0);
    chk("cyc_full", last_rd, 32'hFFFF_FFFF);
    csr(2'b00, 12'hB00, 32'h0);
    chk("cyc_wrap", last_rd, 32'h0);
    csr(2'b00, 12'hB80, 32'h0);
    chk("cych_wrap", last_rd, 32'h0);
    step(2'b01, 12'hB02, 0, 0, 0, 0, 0, 0, 1, 0);
    step(2'b01, 12'hB82, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 12'h000, 0, 0, 0, 0, 0, 0, 1, 0);
    csr(2'b00, 12'hB02, 32'h0);
    chk("instret3", last_rd, 32'h3);

    csr(2'b01, 12'h304, 32'h80);
    csr(2'b10, 12'h300, 32'h8);
    step(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    step(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    chk("irq_pend1", {31'b0, irq_pending_o}, 32'h1);
    step(2'b01, 12'h300, 32'h8, 1, 32'h3, 32'h40, 0, 0, 0, 3'b010);
    csr(2'b00, 12'h300, 32'h0);
    chk("trap_vs_wr", {31'b0, last_rd[3]}, 32'h0);

    csr(2'b10, 12'h300, 32'h8);
    irq_i = 3'b010;
    csr_addr_i = 12'h300;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_gie", {31'b0, global_int_en_o}, 32'h0);
    chk("arst_pend", {31'b0, irq_pending_o}, 32'h0);
    chk("arst_mepc", mepc_o, 32'h0);
    chk("arst_mstatus", csr_rdata_o, 32'h0000_1800);
    csr_addr_i = 12'hB00;
    #1 chk("arst_mcycle", csr_rdata_o, 32'h0);
    m_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 600; i++) begin
      logic [1:0] op;
      logic [31:0] wd, ca;
      op = 2'($urandom_range(0, 3));
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      ca = $urandom;
      step(op, alist[$urandom_range(0, 19)], wd,
           $urandom_range(0, 15) == 0, ca, $urandom, $urandom,
           $urandom_range(0, 15) == 0, 1'($urandom),
           3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
